block_plotter: RTL and testbench

//  Downstream of the snake datapath; consumes block-draw requests (x, y, colour) and drives vga_adapter.

---
 rtl/block_plotter_pkg.sv | 18 +
 rtl/plot_fifo.sv | 37 +++
 rtl/block_plotter.sv | 102 ++++++++++
 tb/tb_block_plotter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/block_plotter_pkg.sv
// block_plotter_pkg: screen/block geometry, colour constants, FSM encoding and request layout
package block_plotter_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BLOCK_SIZE = 4;
  localparam int FIFO_DEPTH = 4;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_RED = 3'b100;
  localparam logic [2:0] COL_BLUE = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] CLEAR_COLOUR = COL_BLACK;
  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_CLEAR} state_t;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } req_t;
endpackage

// File: rtl/plot_fifo.sv
// plot_fifo: synchronous request FIFO, wrap-bit pointers give full/empty
module plot_fifo
  import block_plotter_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  logic pop_i,
  input  req_t din_i,
  output req_t dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);
  req_t mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end
endmodule

// File: rtl/block_plotter.sv
// block_plotter: queues block-draw requests and expands each into single-pixel
// vga writes; also sweeps the whole screen to CLEAR_COLOUR on request.
module block_plotter
  import block_plotter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [2:0] req_colour,
  input  logic       clear_start,
  output logic       busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);
  state_t state_q, state_d;
  req_t head, req_in, base_q, base_d;
  logic [7:0] px_q, px_d, x_lim, x_d;
  logic [6:0] py_q, py_d, y_lim, y_d;
  logic [2:0] c_d;
  logic [8:0] sx;
  logic [7:0] sy;
  logic clear_pend_q, clear_pend_d, plot_d;
  logic full, empty, push, pop, wrap_x, done, clear_go, dispatch;

  assign req_ready = !full && state_q != S_CLEAR && !clear_pend_q;
  assign push = req_valid && req_ready;
  assign busy = !empty || state_q != S_IDLE || clear_pend_q;
  assign req_in = {req_x, req_y, req_colour};
  // Unwrapped sums so off-screen pixels are clipped rather than wrapped to 0
  assign sx = {1'b0, base_q.x} + {1'b0, px_q};
  assign sy = {1'b0, base_q.y} + {1'b0, py_q};
  assign x_lim = state_q == S_CLEAR ? 8'(SCREEN_W - 1) : 8'(BLOCK_SIZE - 1);
  assign y_lim = state_q == S_CLEAR ? 7'(SCREEN_H - 1) : 7'(BLOCK_SIZE - 1);
  assign wrap_x = px_q == x_lim;
  assign done = wrap_x && py_q == y_lim;
  assign clear_go = clear_pend_q || clear_start;
  assign dispatch = !(state_q inside {S_DRAW, S_CLEAR}) || (state_q == S_DRAW && done);

  plot_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (req_in),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    base_d = base_q;
    pop = 1'b0;
    px_d = wrap_x ? '0 : px_q + 8'd1;
    py_d = wrap_x ? py_q + 7'd1 : py_q;
    x_d = state_q == S_DRAW ? sx[7:0] : state_q == S_CLEAR ? px_q : vga_x;
    y_d = state_q == S_DRAW ? sy[6:0] : state_q == S_CLEAR ? py_q : vga_y;
    c_d = state_q == S_DRAW ? base_q.colour : state_q == S_CLEAR ? CLEAR_COLOUR : vga_colour;
    plot_d = state_q == S_CLEAR ||
             (state_q == S_DRAW && sx < 9'(SCREEN_W) && sy < 8'(SCREEN_H));
    // Block end reloads on the same edge as its last pixel, so blocks run back to back
    if (dispatch) begin
      px_d = '0;
      py_d = '0;
      pop = !clear_go && !empty;
      base_d = pop ? head : base_q;
      state_d = clear_go ? S_CLEAR : pop ? S_DRAW : S_IDLE;
    end else if (state_q == S_CLEAR && done) begin
      state_d = S_IDLE;
    end
    clear_pend_d = (clear_pend_q || (clear_start && state_q == S_DRAW)) && state_d != S_CLEAR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q <= '0;
      px_q <= '0;
      py_q <= '0;
      clear_pend_q <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      px_q <= px_d;
      py_q <= py_d;
      clear_pend_q <= clear_pend_d;
      vga_x <= x_d;
      vga_y <= y_d;
      vga_colour <= c_d;
      vga_plot <= plot_d;
    end
  end
endmodule

// File: tb/tb_block_plotter.sv
// tb_block_plotter: directed steps with a pixel scoreboard filled at stimulus time
module tb_block_plotter;
  logic clk = 1'b0;
  logic reset = 1'b1, req_valid = 1'b0, clear_start = 1'b0;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [2:0] req_colour = '0;
  logic req_ready, busy, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  int checks = 0, errors = 0, cyc = 0, nplot = 0;
  int first_cyc = 0, last_cyc = 0, acc_cyc = 0, idle_cyc = 0, n0 = 0;
  logic [17:0] exp_q[$];

  block_plotter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .clear_start(clear_start),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) if (vga_plot === 1'b1) begin
    if (nplot == 0) first_cyc = cyc;
    nplot++;
    last_cyc = cyc;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL unexpected_plot observed=(%0d,%0d) expected=none", vga_x, vga_y);
    end
    if (exp_q.size() > 0) chk("pixel", {14'd0, vga_x, vga_y, vga_colour}, {14'd0, exp_q.pop_front()});
  end

  task automatic push_block(input int x, input int y, input logic [2:0] c);
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++)
        if (x + dx < 160 && y + dy < 120) exp_q.push_back({8'(x + dx), 7'(y + dy), c});
  endtask

  task automatic push_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) exp_q.push_back({8'(x), 7'(y), 3'b000});
  endtask

  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    logic ok = 1'b0;
    req_x = x; req_y = y; req_colour = c; req_valid = 1'b1;
    for (int t = 0; t < 30000 && !ok; t++) begin
      ok = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    acc_cyc = cyc;
    chk("accept", ok, 1);
  endtask

  task automatic wait_idle(input int bound);
    int t = 0;
    while (busy && t < bound) begin
      @(posedge clk); #1;
      t++;
    end
    idle_cyc = cyc;
    chk("idle_reached", busy, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_xy", {vga_x, vga_y, vga_colour}, 0);
    // single block, latency and hold
    nplot = 0;
    push_block(20, 40, 3'b100);
    send(8'd20, 7'd40, 3'b100);
    n0 = acc_cyc;
    wait_idle(100);
    chk("t1_first", first_cyc, n0 + 2);
    chk("t1_last", last_cyc, n0 + 17);
    chk("t1_count", nplot, 16);
    chk("t1_idle", idle_cyc, n0 + 17);
    chk("t1_hold", {vga_plot, vga_x, vga_y, vga_colour}, {1'b0, 8'd23, 7'd43, 3'b100});
    // five back-to-back requests
    nplot = 0;
    for (int i = 0; i < 5; i++) push_block(10 * i, 5 * i, 3'(i + 1));
    send(8'd0, 7'd0, 3'd1);
    n0 = acc_cyc;
    for (int i = 1; i < 5; i++) send(8'(10 * i), 7'(5 * i), 3'(i + 1));
    chk("t2_acc5", acc_cyc, n0 + 4);
    chk("t2_full", req_ready, 0);
    wait_idle(200);
    chk("t2_count", nplot, 80);
    chk("t2_first", first_cyc, n0 + 2);
    chk("t2_last", last_cyc, n0 + 81);
    // clipped corner block
    nplot = 0;
    push_block(158, 118, 3'b111);
    send(8'd158, 7'd118, 3'b111);
    n0 = acc_cyc;
    wait_idle(100);
    chk("t3_count", nplot, 4);
    chk("t3_last", last_cyc, n0 + 7);
    chk("t3_idle", idle_cyc, n0 + 17);
    chk("t3_hold", {vga_x, vga_y}, {8'd161, 7'd121});
    // push and pop on the same edge with three queued
    nplot = 0;
    push_block(0, 100, 3'd1);
    send(8'd0, 7'd100, 3'd1);
    n0 = acc_cyc;
    for (int i = 1; i < 4; i++) begin
      push_block(20 * i, 100, 3'(i + 1));
      send(8'(20 * i), 7'd100, 3'(i + 1));
    end
    wait_cyc(n0 + 16);
    push_block(100, 100, 3'd6);
    send(8'd100, 7'd100, 3'd6);
    chk("t6_acc", acc_cyc, n0 + 17);
    chk("t6_not_full", req_ready, 1);
    wait_idle(200);
    chk("t6_count", nplot, 80);
    chk("t6_last", last_cyc, n0 + 81);
    // clear requested mid-block with one queued request
    nplot = 0;
    push_block(10, 10, 3'b001);
    send(8'd10, 7'd10, 3'b001);
    n0 = acc_cyc;
    send(8'd30, 7'd30, 3'b111);
    wait_cyc(n0 + 6);
    clear_start = 1'b1;
    push_clear();
    push_block(30, 30, 3'b111);
    @(posedge clk); #1;
    clear_start = 1'b0;
    chk("t4_pend_ready", req_ready, 0);
    chk("t4_pend_busy", busy, 1);
    wait_idle(20000);
    chk("t4_count", nplot, 16 + 19200 + 16);
    chk("t4_last", last_cyc, n0 + 19234);
    // reset mid-clear with two queued
    nplot = 0;
    push_block(50, 50, 3'b010);
    send(8'd50, 7'd50, 3'b010);
    n0 = acc_cyc;
    send(8'd60, 7'd60, 3'b011);
    send(8'd70, 7'd70, 3'b101);
    clear_start = 1'b1;
    push_clear();
    @(posedge clk); #1;
    clear_start = 1'b0;
    wait_cyc(n0 + 117);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_plot", vga_plot, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 1);
    reset = 1'b0;
    chk("t5_count", nplot, 116);
    exp_q.delete();
    repeat (40) begin @(posedge clk); #1; end
    chk("t5_quiet", nplot, 116);
    chk("t5_still_idle", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
